// File: rtl/adder_pkg.sv
// Shared definitions for the AXI-Lite adder master: register map, response
// codes and the sequencing state enumeration.
package adder_pkg;

  localparam logic [7:0] OFF_OPA = 8'h00;
  localparam logic [7:0] OFF_OPB = 8'h04;
  localparam logic [7:0] OFF_SUM = 8'h08;
  localparam logic [7:0] OFF_OVF = 8'h0C;

  localparam int RESP_OKAY = 0;

  typedef enum logic [3:0] {
    IDLE,
    WR_A,
    WR_A_RESP,
    WR_B,
    WR_B_RESP,
    RD_SUM_AR,
    RD_SUM_R,
    RD_OVF_AR,
    RD_OVF_R,
    DONE
  } state_e;

  // Every state except IDLE and DONE waits on a slave handshake.
  function automatic logic is_wait_state(state_e s);
    return !(s == IDLE || s == DONE);
  endfunction

endpackage

// File: rtl/axil_timeout_cnt.sv
// Counts cycles spent in the current wait state; expired flags the last
// permitted cycle so the FSM can bail out on that edge.
module axil_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cur;

  // restart marks the first cycle of a freshly entered state
  assign cur     = restart ? '0 : cnt;
  assign expired = run && (cur == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cur != LAST) begin
      cnt <= cur + CW'(1);
    end
  end

endmodule

// File: rtl/adder_master.sv
// AXI-Lite master that writes two operands to a remote adder, reads back the
// sum and overflow flag, and reports completion, errors and timeouts.
module adder_master
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int RESP_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_aresetn,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    overflow,
  output logic                    error,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic [RESP_WIDTH-1:0]   m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic [RESP_WIDTH-1:0]   m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  localparam logic [RESP_WIDTH-1:0] OKAY = RESP_WIDTH'(RESP_OKAY);

  state_e                state;
  logic                  entered;
  logic                  aw_done, w_done;
  logic                  aw_ok, w_ok;
  logic                  tmo;
  logic                  wait_st;
  logic [DATA_WIDTH-1:0] opb_q;

  // AW and W complete independently; either may finish first
  assign aw_ok        = aw_done || (m1_axi_awvalid && m1_axi_awready);
  assign w_ok         = w_done  || (m1_axi_wvalid  && m1_axi_wready);
  assign wait_st      = is_wait_state(state);
  assign m1_axi_wstrb = '1;

  axil_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (m1_axi_aclk),
    .rst_n   (m1_axi_aresetn),
    .restart (entered),
    .run     (wait_st),
    .expired (tmo)
  );

  always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
    if (!m1_axi_aresetn) begin
      state          <= IDLE;
      entered        <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      opb_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      overflow       <= 1'b0;
      result         <= '0;
      m1_axi_awaddr  <= '0;
      m1_axi_awvalid <= 1'b0;
      m1_axi_wdata   <= '0;
      m1_axi_wvalid  <= 1'b0;
      m1_axi_bready  <= 1'b0;
      m1_axi_araddr  <= '0;
      m1_axi_arvalid <= 1'b0;
      m1_axi_rready  <= 1'b0;
    end else begin
      done    <= 1'b0;
      entered <= 1'b0;
      case (state)
        IDLE: if (start) begin
          opb_q          <= op_b;
          error          <= 1'b0;
          busy           <= 1'b1;
          m1_axi_awaddr  <= ADDR_WIDTH'(OFF_OPA);
          m1_axi_wdata   <= op_a;
          m1_axi_awvalid <= 1'b1;
          m1_axi_wvalid  <= 1'b1;
          state          <= WR_A;
          entered        <= 1'b1;
        end
        WR_A, WR_B: begin
          if (aw_ok && w_ok) begin
            m1_axi_awvalid <= 1'b0;
            m1_axi_wvalid  <= 1'b0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            m1_axi_bready  <= 1'b1;
            state          <= (state == WR_A) ? WR_A_RESP : WR_B_RESP;
            entered        <= 1'b1;
          end else if (tmo) begin
            m1_axi_awvalid <= 1'b0;
            m1_axi_wvalid  <= 1'b0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            error          <= 1'b1;
            state          <= DONE;
          end else begin
            if (m1_axi_awvalid && m1_axi_awready) begin
              m1_axi_awvalid <= 1'b0;
              aw_done        <= 1'b1;
            end
            if (m1_axi_wvalid && m1_axi_wready) begin
              m1_axi_wvalid <= 1'b0;
              w_done        <= 1'b1;
            end
          end
        end
        WR_A_RESP, WR_B_RESP: begin
          if (m1_axi_bvalid) begin
            m1_axi_bready <= 1'b0;
            entered       <= 1'b1;
            if (m1_axi_bresp != OKAY) begin
              error <= 1'b1;
              state <= DONE;
            end else if (state == WR_A_RESP) begin
              m1_axi_awaddr  <= ADDR_WIDTH'(OFF_OPB);
              m1_axi_wdata   <= opb_q;
              m1_axi_awvalid <= 1'b1;
              m1_axi_wvalid  <= 1'b1;
              state          <= WR_B;
            end else begin
              m1_axi_araddr  <= ADDR_WIDTH'(OFF_SUM);
              m1_axi_arvalid <= 1'b1;
              state          <= RD_SUM_AR;
            end
          end else if (tmo) begin
            m1_axi_bready <= 1'b0;
            error         <= 1'b1;
            state         <= DONE;
          end
        end
        RD_SUM_AR, RD_OVF_AR: begin
          if (m1_axi_arready) begin
            m1_axi_arvalid <= 1'b0;
            m1_axi_rready  <= 1'b1;
            state          <= (state == RD_SUM_AR) ? RD_SUM_R : RD_OVF_R;
            entered        <= 1'b1;
          end else if (tmo) begin
            m1_axi_arvalid <= 1'b0;
            error          <= 1'b1;
            state          <= DONE;
          end
        end
        RD_SUM_R, RD_OVF_R: begin
          if (m1_axi_rvalid) begin
            m1_axi_rready <= 1'b0;
            entered       <= 1'b1;
            if (m1_axi_rresp != OKAY) begin
              error <= 1'b1;
              state <= DONE;
            end else if (state == RD_SUM_R) begin
              result         <= m1_axi_rdata;
              m1_axi_araddr  <= ADDR_WIDTH'(OFF_OVF);
              m1_axi_arvalid <= 1'b1;
              state          <= RD_OVF_AR;
            end else begin
              overflow <= m1_axi_rdata[0];
              state    <= DONE;
            end
          end else if (tmo) begin
            m1_axi_rready <= 1'b0;
            error         <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_master.sv
// Self-checking bench for adder_master: a behavioural AXI-Lite adder slave,
// a channel monitor, and directed plus randomized scenarios.
module tb_adder_master;

  localparam int DW = 32, AW = 8, RW = 3, TMO = 16;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [DW-1:0] op_a = '0, op_b = '0, result, wdata, rdata;
  logic busy, done, error, overflow;
  logic [AW-1:0] awaddr, araddr;
  logic [DW/8-1:0] wstrb;
  logic [RW-1:0] bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;

  int checks = 0, errors = 0;
  int aw_wait = 0, w_wait = 0, bad_write_idx = -1;
  bit ar_block = 1'b0;
  logic [AW-1:0] wr_addr_q[$], rd_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int aw_runs[$], w_runs[$], ar_runs[$];
  int stab_err = 0;

  adder_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .TIMEOUT_CYCLES(TMO)) dut (
    .m1_axi_aclk(clk), .m1_axi_aresetn(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .error(error),
    .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
    .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(wready),
    .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(bready),
    .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(arready),
    .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
  );

  always #5 clk = ~clk;

  // Reference: the remote adder's wrapped sum and carry-out.
  function automatic logic [DW-1:0] ref_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a + b;
  endfunction
  function automatic logic ref_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint unsigned s;
    s = longint'(a) + longint'(b);
    return s >= 64'h1_0000_0000;
  endfunction

  // Slave: observe handshakes mid-cycle, respond just after the next edge.
  initial begin : slave
    bit s_aw, s_w, s_b, s_ar, s_r, have_aw, have_w;
    logic [AW-1:0] s_awaddr, s_araddr, p_addr;
    logic [DW-1:0] s_wdata, p_data, mem_a, mem_b;
    logic [DW:0] sum33;
    int aw_seen, w_seen;
    have_aw = 0; have_w = 0; aw_seen = 0; w_seen = 0; mem_a = '0; mem_b = '0;
    p_addr = '0; p_data = '0;
    awready = 1; wready = 1; arready = 1; bvalid = 0; bresp = '0; rvalid = 0; rdata = '0; rresp = '0;
    forever begin
      @(negedge clk);
      s_aw = awvalid && awready; s_awaddr = awaddr;
      s_w  = wvalid && wready;   s_wdata  = wdata;
      s_b  = bvalid && bready;
      s_ar = arvalid && arready; s_araddr = araddr;
      s_r  = rvalid && rready;
      @(posedge clk); #1;
      if (!rst_n) begin
        have_aw = 0; have_w = 0; aw_seen = 0; w_seen = 0;
        bvalid = 0; rvalid = 0; awready = 1; wready = 1; arready = !ar_block;
        continue;
      end
      if (s_aw) begin have_aw = 1; p_addr = s_awaddr; aw_seen = 0; end
      if (s_w)  begin have_w = 1;  p_data = s_wdata;  w_seen = 0;  end
      if (s_b) bvalid = 0;
      if (s_r) rvalid = 0;
      if (have_aw && have_w) begin
        bresp = (wr_addr_q.size() == bad_write_idx) ? 3'd2 : 3'd0;
        wr_addr_q.push_back(p_addr); wr_data_q.push_back(p_data);
        if (p_addr == 8'h00) mem_a = p_data;
        else if (p_addr == 8'h04) mem_b = p_data;
        bvalid = 1; have_aw = 0; have_w = 0;
      end
      if (s_ar) begin
        rd_addr_q.push_back(s_araddr);
        sum33 = {1'b0, mem_a} + {1'b0, mem_b};
        rdata = (s_araddr == 8'h08) ? sum33[DW-1:0] :
                (s_araddr == 8'h0C) ? {{(DW-1){1'b0}}, sum33[DW]} : '0;
        rresp = '0; rvalid = 1;
      end
      if (awvalid && aw_seen < aw_wait) begin awready = 0; aw_seen++; end else awready = 1;
      if (wvalid && w_seen < w_wait) begin wready = 0; w_seen++; end else wready = 1;
      arready = !ar_block;
    end
  end

  // Monitor: valid run lengths and address/data stability while valid is held.
  int awr = 0, wr = 0, arr = 0;
  bit pav = 0, pwv = 0;
  logic [AW-1:0] pa = '0;
  logic [DW-1:0] pd = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      awr = 0; wr = 0; arr = 0; pav = 0; pwv = 0;
    end else begin
      if (awvalid && pav && awaddr !== pa) stab_err++;
      if (wvalid && pwv && wdata !== pd) stab_err++;
      if (awvalid) awr++; else if (awr > 0) begin aw_runs.push_back(awr); awr = 0; end
      if (wvalid) wr++;   else if (wr > 0)  begin w_runs.push_back(wr);   wr = 0;  end
      if (arvalid) arr++; else if (arr > 0) begin ar_runs.push_back(arr); arr = 0; end
      pav = awvalid; pa = awaddr; pwv = wvalid; pd = wdata;
    end
  end

  task automatic run_seq(input logic [DW-1:0] a, input logic [DW-1:0] b, output int lat, output bit to);
    op_a = a; op_b = b; start = 1;
    @(posedge clk); #1;
    start = 0; lat = 0; to = 1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; to = 0; break; end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({busy, done, error, overflow} !== 4'b0) begin
      errors++; $display("FAIL %s_flags got %b exp 0000", tag, {busy, done, error, overflow});
    end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL %s_result got %0h exp 0", tag, result); end
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      errors++; $display("FAIL %s_handshake got %b exp 00000", tag, {awvalid, wvalid, bready, arvalid, rready});
    end
    checks++;
    if ({awaddr, araddr, wdata} !== '0) begin
      errors++; $display("FAIL %s_addr_data got %0h/%0h/%0h exp 0", tag, awaddr, araddr, wdata);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    #3 check_idle_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat, wb, rb; bit to;
    wb = wr_addr_q.size(); rb = rd_addr_q.size();
    run_seq(32'd5, 32'd7, lat, to);
    checks++; if (to || lat != 9) begin errors++; $display("FAIL basic_latency got %0d (timeout %0d) exp 9", lat, to); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL basic_result got %0d exp 12", result); end
    checks++; if ({overflow, error, busy} !== 3'b0) begin errors++; $display("FAIL basic_flags got %b exp 000", {overflow, error, busy}); end
    checks++; if (wstrb !== 4'hF) begin errors++; $display("FAIL basic_wstrb got %h exp f", wstrb); end
    checks++;
    if (wr_addr_q.size() - wb != 2 || wr_addr_q[wb] !== 8'h00 || wr_data_q[wb] !== 32'd5 ||
        wr_addr_q[wb+1] !== 8'h04 || wr_data_q[wb+1] !== 32'd7) begin
      errors++; $display("FAIL basic_writes got %0d writes exp 0x00=5,0x04=7", wr_addr_q.size() - wb);
    end
    checks++;
    if (rd_addr_q.size() - rb != 2 || rd_addr_q[rb] !== 8'h08 || rd_addr_q[rb+1] !== 8'h0C) begin
      errors++; $display("FAIL basic_reads got %0d reads exp 0x08,0x0C", rd_addr_q.size() - rb);
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_reset_mid;
    int lat; bit to, seen;
    op_a = 32'd40; op_b = 32'd2; start = 1;
    @(posedge clk); #1; start = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (rready) seen = 1; else begin @(posedge clk); #1; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_reach_rd_sum_r got rready 0 exp 1"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b exp 1", busy); end
    #2 rst_n = 0;
    #1 check_idle_outputs("rstmid");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    run_seq(32'd100, 32'd23, lat, to);
    checks++; if (to || lat != 9) begin errors++; $display("FAIL rstmid_latency got %0d exp 9", lat); end
    checks++; if (result !== 32'd123 || error !== 1'b0) begin
      errors++; $display("FAIL rstmid_result got %0d err %b exp 123 err 0", result, error);
    end
  endtask

  task automatic test_overflow;
    int lat; bit to;
    run_seq(32'hFFFF_FFFF, 32'd1, lat, to);
    checks++; if (to) begin errors++; $display("FAIL ovf_timeout got no done exp done"); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL ovf_result got %0h exp 0", result); end
    checks++; if (overflow !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL ovf_flags got ovf %b err %b exp 1 0", overflow, error);
    end
  endtask

  task automatic test_aw_delay;
    int lat, ab, wb, se; bit to;
    aw_wait = 3; w_wait = 0;
    ab = aw_runs.size(); wb = w_runs.size(); se = stab_err;
    run_seq(32'h1234, 32'h4321, lat, to);
    aw_wait = 0;
    checks++; if (to || lat != 15) begin errors++; $display("FAIL awdly_latency got %0d exp 15", lat); end
    checks++; if (aw_runs.size() - ab != 2 || aw_runs[ab] != 4) begin
      errors++; $display("FAIL awdly_awvalid_cycles got %0d exp 4", (aw_runs.size() > ab) ? aw_runs[ab] : 0);
    end
    checks++; if (w_runs.size() - wb != 2 || w_runs[wb] != 1) begin
      errors++; $display("FAIL awdly_wvalid_cycles got %0d exp 1", (w_runs.size() > wb) ? w_runs[wb] : 0);
    end
    checks++; if (stab_err != se) begin errors++; $display("FAIL awdly_stability got %0d changes exp 0", stab_err - se); end
    checks++; if (result !== 32'h5555 || error !== 1'b0) begin
      errors++; $display("FAIL awdly_result got %0h err %b exp 5555 err 0", result, error);
    end
  endtask

  task automatic test_bresp_error;
    int lat, wb, rb, ab, arb; bit to;
    wb = wr_addr_q.size(); rb = rd_addr_q.size(); ab = aw_runs.size(); arb = ar_runs.size();
    bad_write_idx = wb;
    run_seq(32'd9, 32'd9, lat, to);
    bad_write_idx = -1;
    checks++; if (to) begin errors++; $display("FAIL bresp_done got no done exp done"); end
    checks++; if (error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bresp_error got err %b busy %b exp 1 0", error, busy);
    end
    checks++; if (wr_addr_q.size() - wb != 1 || aw_runs.size() - ab != 1) begin
      errors++; $display("FAIL bresp_aw_count got %0d exp 1", aw_runs.size() - ab);
    end
    checks++; if (rd_addr_q.size() != rb || ar_runs.size() != arb) begin
      errors++; $display("FAIL bresp_ar_count got %0d exp 0", ar_runs.size() - arb);
    end
  endtask

  task automatic test_timeout;
    int lat, arb; bit to;
    ar_block = 1; arb = ar_runs.size();
    run_seq(32'd1, 32'd2, lat, to);
    ar_block = 0;
    checks++; if (to) begin errors++; $display("FAIL tmo_done got no done exp done"); end
    checks++; if (ar_runs.size() - arb != 1 || ar_runs[arb] != TMO) begin
      errors++; $display("FAIL tmo_arvalid_cycles got %0d exp %0d", (ar_runs.size() > arb) ? ar_runs[arb] : 0, TMO);
    end
    checks++; if (error !== 1'b1 || arvalid !== 1'b0) begin
      errors++; $display("FAIL tmo_error got err %b arvalid %b exp 1 0", error, arvalid);
    end
  endtask

  task automatic test_random;
    int lat, exp_lat, wb, se; bit to;
    logic [DW-1:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom;
      if (i == 0) b = ~a + 32'd1;
      aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
      exp_lat = 9 + 2 * ((aw_wait > w_wait) ? aw_wait : w_wait);
      wb = wr_addr_q.size(); se = stab_err;
      if (i % 3 == 1) begin @(posedge clk); #1; end
      run_seq(a, b, lat, to);
      checks++; if (to || lat != exp_lat) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", i, lat, exp_lat); end
      checks++; if (result !== ref_sum(a, b) || overflow !== ref_ovf(a, b) || error !== 1'b0) begin
        errors++; $display("FAIL rand%0d_result got %0h ovf %b err %b exp %0h ovf %b err 0",
                           i, result, overflow, error, ref_sum(a, b), ref_ovf(a, b));
      end
      checks++; if (wr_data_q.size() - wb != 2 || wr_data_q[wb] !== a || wr_data_q[wb+1] !== b || stab_err != se) begin
        errors++; $display("FAIL rand%0d_writes got %0d writes stab %0d exp a,b stable", i, wr_data_q.size() - wb, stab_err - se);
      end
    end
    aw_wait = 0; w_wait = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_reset_mid;
    test_overflow;
    test_aw_delay;
    test_bresp_error;
    test_timeout;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_master.md
ADDER_MASTER -- requirements
Module: adder_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite data width and operand width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, AXI-Lite address width.
REQ-003 SHALL have parameter RESP_WIDTH, default 3, width of bresp/rresp.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum wait cycles per channel handshake.
REQ-005 SHALL have one clock and an asynchronous active-low reset: m1_axi_aclk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have m1_axi_aresetn  in  1  asynchronous active-low reset.
REQ-007 SHALL have start  in  1  begin one add sequence; sampled only in IDLE.
REQ-008 SHALL have op_a / op_b  in  DATA_WIDTH each  operands, captured when start is accepted.
REQ-009 SHALL have busy  out  1  high from start acceptance until done.
REQ-010 SHALL have done  out  1  single-cycle completion pulse.
REQ-011 SHALL have result  out  DATA_WIDTH  sum read back from offset 0x08.
REQ-012 SHALL have overflow  out  1  bit 0 of data read back from offset 0x0C.
REQ-013 SHALL have error  out  1  non-zero response or timeout occurred in the last sequence.
REQ-014 SHALL have m1_axi_awaddr  out  ADDR_WIDTH / m1_axi_awvalid  out  1 / m1_axi_awready  in  1  write address channel.
REQ-015 SHALL have m1_axi_wdata  out  DATA_WIDTH / m1_axi_wstrb  out  DATA_WIDTH/8 / m1_axi_wvalid  out  1 / m1_axi_wready  in  1  write data channel.
REQ-016 SHALL have m1_axi_bresp  in  RESP_WIDTH / m1_axi_bvalid  in  1 / m1_axi_bready  out  1  write response channel.
REQ-017 SHALL have m1_axi_araddr  out  ADDR_WIDTH / m1_axi_arvalid  out  1 / m1_axi_arready  in  1  read address channel.
REQ-018 SHALL have m1_axi_rdata  in  DATA_WIDTH / m1_axi_rresp  in  RESP_WIDTH / m1_axi_rvalid  in  1 / m1_axi_rready  out  1  read data channel.

Function
REQ-019 SHALL sequence states IDLE -> WR_A -> WR_A_RESP -> WR_B -> WR_B_RESP -> RD_SUM_AR -> RD_SUM_R -> RD_OVF_AR -> RD_OVF_R -> DONE -> IDLE.
REQ-020 SHALL in IDLE with start=1 latch op_a/op_b, clear error, assert busy, enter WR_A next cycle; start while busy is ignored.
REQ-021 SHALL in WR_A/WR_B drive awvalid=wvalid=1 (addr 0x00/0x04, wdata latched A/B, wstrb all ones), drop each valid on its own valid&&ready cycle, advance when both have completed.
REQ-022 SHALL hold awaddr/wdata stable while the corresponding valid is high.
REQ-023 SHALL assert bready only in *_RESP states and rready only in *_R states; advance on the bvalid/rvalid handshake cycle.
REQ-024 SHALL drive arvalid=1 with araddr 0x08/0x0C in RD_*_AR until arready, then deassert.
REQ-025 SHALL register result <= rdata on the RD_SUM_R handshake and overflow <= rdata[0] on the RD_OVF_R handshake.
REQ-026 SHALL on bresp or rresp != 0 set error=1, drop all valids/readies, and jump to DONE.
REQ-027 SHALL count cycles per wait state (counter cleared on state entry); at TIMEOUT_CYCLES without handshake set error=1, drop valids, jump to DONE.
REQ-028 SHALL in DONE pulse done=1 for one cycle, deassert busy, return to IDLE; result/overflow/error hold until next start.
REQ-029 SHALL complete in 9 cycles from start sampling to done with a zero-wait slave (ready high, responses one cycle after handshake).

Reset
REQ-030 SHALL on m1_axi_aresetn=0, immediately and regardless of state: state=IDLE; all valid/ready, busy, done, error, overflow=0; result=0; addresses/wdata=0; timeout counter=0.

Structure
REQ-031 SHALL take register offsets (OFF_OPA=0x00, OFF_OPB=0x04, OFF_SUM=0x08, OFF_OVF=0x0C), RESP_OKAY=0 and the state enumeration from shared package adder_pkg.
REQ-032 SHALL implement the per-channel timeout counter as one sub-module, axil_timeout_cnt; all else in one FSM.

Verification
REQ-033 SHALL test A=5, B=7, zero-wait slave returning 12 / 0 -> writes 0x00=5, 0x04=7; result=12, overflow=0, error=0, done 9 cycles after start.
REQ-034 SHALL test A=0xFFFFFFFF, B=1, slave returning 0 / 1 -> result=0, overflow=1, error=0.
REQ-035 SHALL test awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, addr/data stable, sequence completes.
REQ-036 SHALL test bresp=2 on first write -> error=1, done pulses, no AW/AR issued to 0x04/0x08/0x0C.
REQ-037 SHALL test TIMEOUT_CYCLES=16, arready never asserted -> arvalid drops after 16 cycles, error=1, done pulses.
REQ-038 SHALL test reset asserted during RD_SUM_R -> all outputs at reset values asynchronously; a new start after release runs a full sequence.
